// File: rtl/ring_recv_unit.sv
// ring_recv_unit: receive end of one ring link.
// Messages whose destination field matches this node are ejected into a small
// FIFO toward the local terminal; all others pass through a one-entry
// pipelined forward register toward the downstream link. Every stored entry
// carries its security-domain bit next to the data it labels.

`ifndef RING_ASSERT_KNOWN
`define RING_ASSERT_KNOWN(name, sig, clk, rst_n) \
  name: assert property (@(posedge clk) disable iff (!(rst_n)) !$isunknown(sig))
`endif

module ring_recv_unit #(
  parameter int p_msg_nbits   = 32,
  parameter int p_dest_nbits  = 2,
  parameter int p_node_id     = 0,
  parameter int p_eject_depth = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [p_msg_nbits-1:0]             in_msg,
  input  logic                               in_domain,
  output logic                               fwd_val,
  input  logic                               fwd_rdy,
  output logic [p_msg_nbits-1:0]             fwd_msg,
  output logic                               fwd_domain,
  output logic                               ej_val,
  input  logic                               ej_rdy,
  output logic [p_msg_nbits-1:0]             ej_msg,
  output logic                               ej_domain,
  output logic [$clog2(p_eject_depth):0]     ej_count
);

  localparam int c_ptr_nbits = $clog2(p_eject_depth);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;

  logic [p_dest_nbits-1:0] dest;
  logic                    hit;
  logic                    ej_full;
  logic                    in_xfer;
  logic                    ej_wr;
  logic                    ej_rd;
  logic                    fwd_ld;
  logic                    fwd_xfer;

  logic [c_ptr_nbits-1:0]  wr_ptr;
  logic [c_ptr_nbits-1:0]  rd_ptr;
  logic [p_msg_nbits:0]    ej_mem [p_eject_depth];

  // Destination decode and handshake qualification; a message is steered to
  // exactly one path because ej_wr and fwd_ld are split on hit.
  always_comb begin
    dest     = in_msg[p_msg_nbits-1 -: p_dest_nbits];
    hit      = (dest == p_dest_nbits'(p_node_id));
    ej_full  = (ej_count == c_cnt_nbits'(p_eject_depth));
    in_rdy   = hit ? !ej_full : (!fwd_val || fwd_rdy);
    in_xfer  = in_val && in_rdy;
    ej_wr    = in_xfer && hit;
    fwd_ld   = in_xfer && !hit;
    fwd_xfer = fwd_val && fwd_rdy;
    ej_rd    = ej_val && ej_rdy;
  end

  // Forward register valid bit: a new load wins over a drain so the link
  // sustains one message per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_val <= 1'b0;
    end else if (fwd_ld) begin
      fwd_val <= 1'b1;
    end else if (fwd_xfer) begin
      fwd_val <= 1'b0;
    end
  end

  // Forward payload and domain are data-only registers, meaningful only
  // while fwd_val is high.
  always_ff @(posedge clk) begin
    if (fwd_ld) begin
      fwd_msg    <= in_msg;
      fwd_domain <= in_domain;
    end
  end

  // Eject FIFO pointers and occupancy; pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ej_count <= '0;
    end else begin
      if (ej_wr) begin
        wr_ptr <= wr_ptr + c_ptr_nbits'(1);
      end
      if (ej_rd) begin
        rd_ptr <= rd_ptr + c_ptr_nbits'(1);
      end
      case ({ej_wr, ej_rd})
        2'b10:   ej_count <= ej_count + c_cnt_nbits'(1);
        2'b01:   ej_count <= ej_count - c_cnt_nbits'(1);
        default: ej_count <= ej_count;
      endcase
    end
  end

  // Eject FIFO storage keeps the domain bit in the top position of each entry.
  always_ff @(posedge clk) begin
    if (ej_wr) begin
      ej_mem[wr_ptr] <= {in_domain, in_msg};
    end
  end

  // Head of the FIFO drives the terminal side directly from registers.
  always_comb begin
    ej_val    = (ej_count != '0);
    ej_msg    = ej_mem[rd_ptr][p_msg_nbits-1:0];
    ej_domain = ej_mem[rd_ptr][p_msg_nbits];
  end

  `RING_ASSERT_KNOWN(a_in_val_known, in_val, clk, reset);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(ej_wr && ej_full));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(ej_rd && (ej_count == '0)));

endmodule

// File: tb/tb_ring_recv_unit.sv
// tb_ring_recv_unit: directed scenario bench for ring_recv_unit with node 0,
// 32-bit messages, 2-bit destination field and a two-entry eject FIFO.

module tb_ring_recv_unit;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        in_domain;
  logic        fwd_val;
  logic        fwd_rdy;
  logic [31:0] fwd_msg;
  logic        fwd_domain;
  logic        ej_val;
  logic        ej_rdy;
  logic [31:0] ej_msg;
  logic        ej_domain;
  logic [1:0]  ej_count;

  int errors = 0;
  int checks = 0;

  ring_recv_unit #(
    .p_msg_nbits   (32),
    .p_dest_nbits  (2),
    .p_node_id     (0),
    .p_eject_depth (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .in_domain  (in_domain),
    .fwd_val    (fwd_val),
    .fwd_rdy    (fwd_rdy),
    .fwd_msg    (fwd_msg),
    .fwd_domain (fwd_domain),
    .ej_val     (ej_val),
    .ej_rdy     (ej_rdy),
    .ej_msg     (ej_msg),
    .ej_domain  (ej_domain),
    .ej_count   (ej_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] m, input logic d);
    in_val    = v;
    in_msg    = m;
    in_domain = d;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_val = 1'b0; in_msg = '0; in_domain = 1'b0;
    fwd_rdy = 1'b1; ej_rdy = 1'b0;
    tick(); tick();
    checks++; if (fwd_val !== 1'b0) begin errors++; $display("[TB] FAIL rst_fwd_val: got %b expected 0", fwd_val); end
    checks++; if (ej_val !== 1'b0) begin errors++; $display("[TB] FAIL rst_ej_val: got %b expected 0", ej_val); end
    checks++; if (ej_count !== 2'd0) begin errors++; $display("[TB] FAIL rst_ej_count: got %0d expected 0", ej_count); end
    drive(1'b1, 32'h0000_0001, 1'b0);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_rdy_hit: got %b expected 1", in_rdy); end
    tick();
    checks++; if (ej_count !== 2'd0) begin errors++; $display("[TB] FAIL rst_no_xfer: got %0d expected 0", ej_count); end
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_forward_stream();
    logic [31:0] msgs [3];
    msgs[0] = 32'h4000_0001; msgs[1] = 32'h4000_0002; msgs[2] = 32'h4000_0003;
    fwd_rdy = 1'b1; ej_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, msgs[i], 1'b0);
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_rdy[%0d]: got %b expected 1", i, in_rdy); end
      tick();
      checks++; if (fwd_val !== 1'b1 || fwd_msg !== msgs[i]) begin errors++; $display("[TB] FAIL stream_fwd[%0d]: got val=%b msg=%h expected val=1 msg=%h", i, fwd_val, fwd_msg, msgs[i]); end
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (fwd_val !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", fwd_val); end
    checks++; if (ej_count !== 2'd0) begin errors++; $display("[TB] FAIL stream_no_eject: got %0d expected 0", ej_count); end
  endtask

  task automatic test_fwd_backpressure();
    fwd_rdy = 1'b0;
    drive(1'b1, 32'h4000_0005, 1'b0);
    tick();
    checks++; if (fwd_val !== 1'b1 || fwd_msg !== 32'h4000_0005) begin errors++; $display("[TB] FAIL bp_hold: got val=%b msg=%h expected val=1 msg=40000005", fwd_val, fwd_msg); end
    drive(1'b1, 32'h4000_0006, 1'b0);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_rdy_low: got %b expected 0", in_rdy); end
    tick();
    checks++; if (fwd_msg !== 32'h4000_0005) begin errors++; $display("[TB] FAIL bp_stalled: got %h expected 40000005", fwd_msg); end
    fwd_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_rdy_high: got %b expected 1", in_rdy); end
    tick();
    checks++; if (fwd_val !== 1'b1 || fwd_msg !== 32'h4000_0006) begin errors++; $display("[TB] FAIL bp_release: got val=%b msg=%h expected val=1 msg=40000006", fwd_val, fwd_msg); end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (fwd_val !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b expected 0", fwd_val); end
  endtask

  task automatic test_eject_full();
    fwd_rdy = 1'b1; ej_rdy = 1'b0;
    drive(1'b1, 32'h0000_0010, 1'b0);
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL full_rdy0: got %b expected 1", in_rdy); end
    tick();
    checks++; if (ej_val !== 1'b1 || ej_count !== 2'd1 || ej_msg !== 32'h10) begin errors++; $display("[TB] FAIL full_first: got val=%b cnt=%0d msg=%h expected val=1 cnt=1 msg=10", ej_val, ej_count, ej_msg); end
    checks++; if (fwd_val !== 1'b0) begin errors++; $display("[TB] FAIL full_no_fwd: got %b expected 0", fwd_val); end
    drive(1'b1, 32'h0000_0011, 1'b0);
    tick();
    checks++; if (ej_count !== 2'd2 || ej_msg !== 32'h10) begin errors++; $display("[TB] FAIL full_second: got cnt=%0d msg=%h expected cnt=2 msg=10", ej_count, ej_msg); end
    drive(1'b1, 32'h0000_0012, 1'b0);
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_in_rdy: got %b expected 0", in_rdy); end
    tick();
    checks++; if (ej_count !== 2'd2) begin errors++; $display("[TB] FAIL full_held: got %0d expected 2", ej_count); end
    ej_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_no_bypass: got %b expected 0", in_rdy); end
    tick();
    checks++; if (ej_count !== 2'd1 || ej_msg !== 32'h11) begin errors++; $display("[TB] FAIL full_pop: got cnt=%0d msg=%h expected cnt=1 msg=11", ej_count, ej_msg); end
    ej_rdy = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL full_reopen: got %b expected 1", in_rdy); end
    tick();
    checks++; if (ej_count !== 2'd2 || ej_msg !== 32'h11) begin errors++; $display("[TB] FAIL full_third: got cnt=%0d msg=%h expected cnt=2 msg=11", ej_count, ej_msg); end
    drive(1'b0, 32'h0, 1'b0);
    ej_rdy = 1'b1;
    tick();
    checks++; if (ej_count !== 2'd1 || ej_msg !== 32'h12) begin errors++; $display("[TB] FAIL full_wrap: got cnt=%0d msg=%h expected cnt=1 msg=12", ej_count, ej_msg); end
    tick();
    checks++; if (ej_val !== 1'b0 || ej_count !== 2'd0) begin errors++; $display("[TB] FAIL full_empty: got val=%b cnt=%0d expected val=0 cnt=0", ej_val, ej_count); end
    ej_rdy = 1'b0;
  endtask

  task automatic test_simultaneous();
    ej_rdy = 1'b0;
    drive(1'b1, 32'h0000_0020, 1'b0);
    tick();
    checks++; if (ej_count !== 2'd1 || ej_msg !== 32'h20) begin errors++; $display("[TB] FAIL sim_setup: got cnt=%0d msg=%h expected cnt=1 msg=20", ej_count, ej_msg); end
    drive(1'b1, 32'h0000_0021, 1'b0);
    ej_rdy = 1'b1;
    tick();
    checks++; if (ej_count !== 2'd1 || ej_msg !== 32'h21) begin errors++; $display("[TB] FAIL sim_rw: got cnt=%0d msg=%h expected cnt=1 msg=21", ej_count, ej_msg); end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    checks++; if (ej_count !== 2'd0) begin errors++; $display("[TB] FAIL sim_drain: got %0d expected 0", ej_count); end
    ej_rdy = 1'b0;
  endtask

  task automatic test_domain();
    fwd_rdy = 1'b1; ej_rdy = 1'b0;
    drive(1'b1, 32'h0000_0030, 1'b1);
    tick();
    checks++; if (ej_msg !== 32'h30 || ej_domain !== 1'b1) begin errors++; $display("[TB] FAIL dom_ej_h: got msg=%h dom=%b expected msg=30 dom=1", ej_msg, ej_domain); end
    drive(1'b1, 32'h4000_0031, 1'b0);
    tick();
    checks++; if (fwd_msg !== 32'h4000_0031 || fwd_domain !== 1'b0) begin errors++; $display("[TB] FAIL dom_fwd_l: got msg=%h dom=%b expected msg=40000031 dom=0", fwd_msg, fwd_domain); end
    drive(1'b1, 32'h0000_0032, 1'b0);
    tick();
    checks++; if (fwd_val !== 1'b0 || ej_count !== 2'd2) begin errors++; $display("[TB] FAIL dom_split: got fwd_val=%b cnt=%0d expected fwd_val=0 cnt=2", fwd_val, ej_count); end
    drive(1'b1, 32'h8000_0033, 1'b1);
    tick();
    checks++; if (fwd_msg !== 32'h8000_0033 || fwd_domain !== 1'b1) begin errors++; $display("[TB] FAIL dom_fwd_h: got msg=%h dom=%b expected msg=80000033 dom=1", fwd_msg, fwd_domain); end
    drive(1'b0, 32'h0, 1'b0);
    ej_rdy = 1'b1;
    tick();
    checks++; if (ej_msg !== 32'h32 || ej_domain !== 1'b0) begin errors++; $display("[TB] FAIL dom_ej_l: got msg=%h dom=%b expected msg=32 dom=0", ej_msg, ej_domain); end
    tick();
    ej_rdy = 1'b0;
  endtask

  task automatic test_reset_midstream();
    fwd_rdy = 1'b0; ej_rdy = 1'b0;
    drive(1'b1, 32'h0000_0001, 1'b0); tick();
    drive(1'b1, 32'h0000_0002, 1'b1); tick();
    drive(1'b1, 32'h4000_0003, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (fwd_val !== 1'b1 || ej_count !== 2'd2) begin errors++; $display("[TB] FAIL mid_setup: got fwd_val=%b cnt=%0d expected fwd_val=1 cnt=2", fwd_val, ej_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (ej_val !== 1'b0 || ej_count !== 2'd0 || fwd_val !== 1'b0) begin errors++; $display("[TB] FAIL mid_async: got ej_val=%b cnt=%0d fwd_val=%b expected 0 0 0", ej_val, ej_count, fwd_val); end
    tick();
    reset = 1'b1;
    fwd_rdy = 1'b1;
    drive(1'b1, 32'h0000_00AA, 1'b0);
    tick();
    checks++; if (ej_val !== 1'b1 || ej_count !== 2'd1 || ej_msg !== 32'hAA) begin errors++; $display("[TB] FAIL mid_after: got val=%b cnt=%0d msg=%h expected val=1 cnt=1 msg=aa", ej_val, ej_count, ej_msg); end
    drive(1'b0, 32'h0, 1'b0);
    ej_rdy = 1'b1;
    tick();
    ej_rdy = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_forward_stream();
    test_fwd_backpressure();
    test_eject_full();
    test_simultaneous();
    test_domain();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
